// File: rtl/fir_sched_pkg.sv
// Shared definitions for the FIR channel scheduler: state encoding, defaults
// and the channel-id width helper.
package fir_sched_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_LENGTH = 50;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_LOAD = 3'd2,
    ST_MAC  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Channel id width; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester strictly after last_grant, wrapping.
// Purely combinational; the caller owns the last_grant register.
module rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              any
);

  always_comb begin : pick
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    // Walk from the farthest candidate back so the nearest one wins last.
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_CH;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = CH_W'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Time-shares one serial FIR datapath among NUM_CH channels: round-robin
// accept, then LOAD / MAC / DONE sequencing with a MAC watchdog.
module fir_channel_scheduler
  import fir_sched_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int LENGTH = DEF_LENGTH,
  parameter  int WDOG   = LENGTH + 4,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    soft_clr,
  input  logic [NUM_CH-1:0]       ch_valid,
  output logic [NUM_CH-1:0]       ch_ready,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  output logic [WIDTH-1:0]        dp_in,
  output logic [CH_W-1:0]         dp_ch_sel,
  output logic                    dp_rst,
  output logic                    dp_shift_enb,
  output logic                    dp_reset_reg,
  output logic                    dp_count_enb,
  output logic                    dp_register_enb,
  input  logic                    dp_roll_back,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_ch,
  output logic                    busy,
  output logic                    err_timeout,
  output logic [2:0]              dbg_state
);

  localparam int WD_W = $clog2(WDOG + 1);

  state_t              state;
  logic [CH_W-1:0]     last_grant;
  logic [WD_W-1:0]     wdog;
  logic [NUM_CH-1:0]   grant;
  logic [CH_W-1:0]     grant_idx;
  logic                grant_any;
  logic                transfer;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req        (ch_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any        (grant_any)
  );

  // Handshake: a sample moves when ch_valid[i] and ch_ready[i] are both high
  // on a rising edge. ch_ready is one-hot on the arbitration winner and only
  // in IDLE; a source may drop valid without a transfer.
  assign ch_ready = (state == ST_IDLE && grant_any) ? grant : '0;
  assign transfer = |(ch_valid & ch_ready);

  assign dp_rst          = (state == ST_INIT);
  assign dp_shift_enb    = (state == ST_LOAD);
  assign dp_reset_reg    = (state == ST_LOAD);
  assign dp_count_enb    = (state == ST_MAC);
  assign dp_register_enb = (state == ST_MAC);
  assign out_valid       = (state == ST_DONE);
  assign busy            = (state != ST_IDLE);
  assign dbg_state       = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_INIT;
      last_grant  <= CH_W'(NUM_CH - 1);
      dp_in       <= '0;
      dp_ch_sel   <= '0;
      out_ch      <= '0;
      err_timeout <= 1'b0;
      wdog        <= '0;
    end else if (soft_clr) begin
      // last_grant survives so the rotation stays fair across a clear.
      state       <= ST_INIT;
      err_timeout <= 1'b0;
      wdog        <= '0;
    end else begin
      case (state)
        ST_INIT: state <= ST_IDLE;
        ST_IDLE: begin
          if (transfer) begin
            dp_in      <= ch_data[grant_idx*WIDTH +: WIDTH];
            dp_ch_sel  <= grant_idx;
            last_grant <= grant_idx;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          wdog  <= '0;
          state <= ST_MAC;
        end
        ST_MAC: begin
          wdog <= wdog + 1'b1;
          if (dp_roll_back) begin
            // Tag is captured on entry so it is valid alongside out_valid.
            out_ch <= dp_ch_sel;
            state  <= ST_DONE;
          end else if (wdog == WD_W'(WDOG - 1)) begin
            err_timeout <= 1'b1;
            state       <= ST_INIT;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
